// File: rtl/trng_pkg.sv
// Shared constants, types and helpers for the multi-channel TRNG sampler.
package trng_pkg;

  localparam int unsigned N_CH_DEF     = 4;
  localparam int unsigned WORD_W_DEF   = 8;
  localparam int unsigned DAC_W_DEF    = 8;
  localparam int unsigned WIN_LOG2_DEF = 8;

  typedef enum logic {
    VN_EMPTY,
    VN_HAVE_ONE
  } vn_state_e;

  // An all-ones window reaches exactly 2**win_log2, which needs one extra bit.
  function automatic int unsigned ones_w(input int unsigned win_log2);
    return win_log2 + 1;
  endfunction

endpackage

// File: rtl/trng_health_win.sv
// Windowed ones-count health monitor: counts ones over 2**WIN_LOG2 strobed samples.
module trng_health_win
  import trng_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_restart,
  input  logic                        i_strobe,
  input  logic                        i_bit,
  output logic [ones_w(WIN_LOG2)-1:0] o_ones_cnt,
  output logic                        o_ones_valid
);

  localparam int unsigned CntW = ones_w(WIN_LOG2);

  logic [WIN_LOG2-1:0] r_win;
  logic [CntW-1:0]     r_acc;
  logic [CntW-1:0]     r_ones;
  logic                r_valid;
  logic [CntW-1:0]     w_acc_next;

  assign w_acc_next = r_acc + CntW'(i_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_restart) begin
        r_win <= '0;
        r_acc <= '0;
      end else if (i_strobe) begin
        // Final sample of the window is folded into the published count.
        if (r_win == '1) begin
          r_ones  <= w_acc_next;
          r_valid <= 1'b1;
          r_win   <= '0;
          r_acc   <= '0;
        end else begin
          r_win <= r_win + 1'b1;
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign o_ones_cnt   = r_ones;
  assign o_ones_valid = r_valid;

endmodule

// File: rtl/trng_sampler_vn.sv
// Multi-channel TRNG sampler: sync, XOR-combine, optional von Neumann debias
// (macro TRNG_VON_NEUMANN_EN), word packing, VDAC code register, health monitor.
module trng_sampler_vn
  import trng_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned DAC_W    = DAC_W_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH-1:0]     raw_i,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                bias_wr,
  input  logic [DAC_W-1:0]    bias_code,
  output logic [DAC_W-1:0]    vdac_code,
  output logic [WORD_W-1:0]   rnd_data,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic [WIN_LOG2:0]   ones_cnt,
  output logic                ones_valid
);

  localparam int unsigned CntW = $clog2(WORD_W);
  localparam logic [CntW-1:0] LastIdx = CntW'(WORD_W - 1);

  logic [N_CH-1:0]   r_sync1, r_sync2;
  logic [DAC_W-1:0]  r_vdac;
  logic [WORD_W-1:0] r_coll;
  logic [CntW-1:0]   r_cnt;
  logic              r_full;
  logic [WORD_W-1:0] r_rnd_data;
  logic              r_rnd_valid;

  logic w_c, w_strobe, w_acc_valid, w_acc_bit, w_move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_c      = ^(r_sync2 & ch_mask);
  assign w_strobe = en & (|ch_mask);

`ifdef TRNG_VON_NEUMANN_EN
  vn_state_e r_vn_state;
  logic      r_vn_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vn_state <= VN_EMPTY;
      r_vn_first <= 1'b0;
    end else if (bias_wr || !w_strobe) begin
      r_vn_state <= VN_EMPTY;
    end else if (r_vn_state == VN_EMPTY) begin
      r_vn_state <= VN_HAVE_ONE;
      r_vn_first <= w_c;
    end else begin
      r_vn_state <= VN_EMPTY;
    end
  end

  assign w_acc_valid = w_strobe & (r_vn_state == VN_HAVE_ONE) & (r_vn_first != w_c);
  assign w_acc_bit   = r_vn_first;
`else
  assign w_acc_valid = w_strobe;
  assign w_acc_bit   = w_c;
`endif

  // A held complete word moves whenever the slot is empty or being drained.
  assign w_move = r_full & (~r_rnd_valid | rnd_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vdac      <= '0;
      r_coll      <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_rnd_data  <= '0;
      r_rnd_valid <= 1'b0;
    end else begin
      if (bias_wr) begin
        r_vdac <= bias_code;
      end

      if (w_move) begin
        r_rnd_data  <= r_coll;
        r_rnd_valid <= 1'b1;
      end else if (r_rnd_valid && rnd_ready) begin
        r_rnd_valid <= 1'b0;
      end

      if (bias_wr) begin
        r_coll <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
      end else begin
        if (w_move) begin
          r_full <= 1'b0;
        end
        // Stale upper bits are shifted out before the next word completes.
        if (w_acc_valid && (!r_full || w_move)) begin
          r_coll <= {r_coll[WORD_W-2:0], w_acc_bit};
          if (r_cnt == LastIdx) begin
            r_cnt  <= '0;
            r_full <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  trng_health_win #(
    .WIN_LOG2(WIN_LOG2)
  ) u_health (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_restart   (bias_wr),
    .i_strobe    (w_strobe),
    .i_bit       (w_c),
    .o_ones_cnt  (ones_cnt),
    .o_ones_valid(ones_valid)
  );

  assign vdac_code = r_vdac;
  assign rnd_data  = r_rnd_data;
  assign rnd_valid = r_rnd_valid;

endmodule

// File: doc/trng_sampler_vn.md
Name: trng_sampler_vn

Overview:
- Multi-channel successor to the single-oscillator biased TRNG.
- Samples N_CH externally generated biased ring-oscillator bits, synchronises them, XOR-combines the enabled channels and optionally von-Neumann debiases them.
- Packs accepted bits into WORD_W words behind a valid/ready handshake.
- Owns the VDAC bias-code register and runs a windowed ones-count health monitor.

Parameters:
- N_CH, 4, number of raw oscillator channels (1..8)
- WORD_W, 8, output word width (2..32)
- DAC_W, 8, VDAC bias-code width
- WIN_LOG2, 8, health window = 2**WIN_LOG2 raw combined samples

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sampling enable
- raw_i  in  N_CH  asynchronous biased-oscillator bits, one per channel
- ch_mask  in  N_CH  per-channel enable for XOR combine
- bias_wr  in  1  load bias_code into vdac_code
- bias_code  in  DAC_W  new VDAC code
- vdac_code  out  DAC_W  registered code driving the VDAC
- rnd_data  out  WORD_W  random word
- rnd_valid  out  1  rnd_data holds an unconsumed word
- rnd_ready  in  1  consumer accepts the word
- ones_cnt  out  WIN_LOG2+1  ones count of the last complete window
- ones_valid  out  1  one-cycle pulse when ones_cnt updates

Behaviour:
- Reset values: all flops asynchronously cleared. vdac_code=0, rnd_data=0, rnd_valid=0, ones_cnt=0, ones_valid=0, bit counter 0, von Neumann (VN) pair state empty.
- Synchroniser: 2 flops per channel. Combined bit c = XOR over (sync & ch_mask). Raw-to-c latency is 2 clk.
- Sample strobe s = en & (ch_mask != 0). One c is evaluated per cycle while s=1.
- With en=0 or mask=0: no bits are accepted, the health window is frozen and the VN pair state is cleared. A partial word is retained.
- Collector:
  - An accepted bit shifts in at bit 0; older bits move toward the MSB.
  - The bit counter counts 0..WORD_W-1.
  - On the WORD_W-th bit, the word is complete.
- Output slot:
  - A complete word moves to rnd_data and sets rnd_valid the cycle after the last bit.
  - Transfer occurs on rnd_valid & rnd_ready.
  - Simultaneous completion and transfer in the same cycle: the new word loads and rnd_valid stays 1.
  - Completion while the slot is full and not transferring: the collector holds the complete word and discards further accepted bits. The held word moves in the cycle the slot frees.
  - rnd_data is stable while rnd_valid=1 and rnd_ready=0.
- Bias register: bias_wr loads vdac_code next edge. The same edge also:
  - clears the collector and bit counter,
  - clears the VN pair state,
  - restarts the health window.
  - The output slot is untouched.
- Health monitor:
  - Counts ones in c over 2**WIN_LOG2 strobed samples, before debiasing.
  - At window end: ones_cnt <= count including the final sample, ones_valid pulses 1 cycle, counters restart.
  - An all-ones window gives ones_cnt = 2**WIN_LOG2, with no overflow.
- Reset mid-word: partial word and held word are lost. Post-reset behaviour is identical to power-up.

Optional Feature:
- Macro TRNG_VON_NEUMANN_EN.
- Defined: strobed bits are paired, first bit stored.
  - On the second bit, unequal pair emits the first bit as one accepted bit.
  - Equal pair emits nothing.
  - Pair state clears on bias_wr or loss of strobe.
- Undefined: every strobed c is an accepted bit.
- The health monitor always observes raw c.

Decomposition:
- Shared package trng_pkg:
  - default constants for N_CH, WORD_W, DAC_W, WIN_LOG2
  - function computing ones_cnt width
  - enum for the VN pair state (VN_EMPTY, VN_HAVE_ONE)
- One sub-module, trng_health_win: window counter plus ones accumulator, with ports clk, rst_n, restart, strobe, bit, ones_cnt, ones_valid.

Test Plan:
- Reset then idle: rst_n low 3 cycles, en=0 -> all outputs 0, rnd_valid never rises over 100 cycles.
- Raw path, macro off:
  - Inputs: N_CH=4, ch_mask=0001, raw_i[0] driving 1,0,1,1,0,0,1,0 on consecutive cycles, rnd_ready=1.
  - Required: rnd_data=8'b10110010, rnd_valid rising 2+8+1 cycles after the first bit.
- Von Neumann, macro on:
  - Input: c pairs 10,11,01,00,10 ...
  - Required: accepted bits 1,0,1; a constant-1 input for 64 cycles produces no word.
- Backpressure:
  - Setup: rnd_ready=0, constant alternating input.
  - Required: first word holds stable; second word completes and holds; further bits are discarded.
  - When rnd_ready pulses 1 cycle: rnd_data takes the second word the next cycle.
- Bias write mid-word: after 5 accepted bits, bias_wr with bias_code=0x5A -> vdac_code=0x5A next cycle, the next word contains only bits accepted after the write, and the health window restarts.
- Health: WIN_LOG2=4, c constant 1 for 16 strobes -> ones_cnt=16, ones_valid pulses once. With c alternating -> ones_cnt=8.
